// File: rtl/exec_md_stage_if.sv
// Execute-stage bus: decode-side instruction/control inputs and writeback-side results.
// master = decode/writeback side, slave = exec_md_stage.
interface exec_md_stage_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            flush_i;
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;
  logic [4:0]      in_op;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic [4:0]      in_dest;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [4:0]      out_dest;
  logic [XLEN-1:0] out_res;
  logic            busy_o;

  modport master (
    output stall_i, flush_i, in_valid, in_pc, in_inst, in_op, in_src1, in_src2, in_dest,
    input  out_valid, out_pc, out_inst, out_dest, out_res, busy_o
  );

  modport slave (
    input  stall_i, flush_i, in_valid, in_pc, in_inst, in_op, in_src1, in_src2, in_dest,
    output out_valid, out_pc, out_inst, out_dest, out_res, busy_o
  );
endinterface

// File: rtl/exec_md_stage.sv
// Execute stage: stage register + single-cycle ALU + iterative RV32M/RV64M mul/div unit.
// Mul/div holds the stage busy for XLEN iterations and back-pressures decode via busy_o.
module exec_md_stage #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic            clk,
  input logic            rst,
  exec_md_stage_if.slave io
);
  localparam logic [4:0] OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_AND = 5'd3,  OP_OR = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5,  OP_LUI = 5'd6,  OP_SLT = 5'd7,  OP_SLTU = 5'd8;
  localparam logic [4:0] OP_SLL = 5'd9,  OP_SRL = 5'd10, OP_SRA = 5'd11;
  localparam logic [4:0] OP_MUL = 5'd12, OP_MULH = 5'd13, OP_MULHSU = 5'd14, OP_MULHU = 5'd15;
  localparam logic [4:0] OP_DIV = 5'd16, OP_DIVU = 5'd17, OP_REM = 5'd18, OP_REMU = 5'd19;
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_e;

  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_w(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic            vld_p0;
  logic [XLEN-1:0] pc_p0, src1_p0, src2_p0;
  logic [31:0]     inst_p0;
  logic [4:0]      op_p0, dest_p0;

  md_state_e       state_q, state_n;
  logic [SHW-1:0]  cnt_q, cnt_n;
  logic [XLEN-1:0] md_hi_p1, md_lo_p1, md_opd_p1;
  logic            md_neg1_p1, md_neg2_p1;

  logic is_alu, is_md, is_div, busy, cap, res_vld;
  assign is_alu = (op_p0 >= OP_ADD) && (op_p0 <= OP_SRA);
  assign is_md  = (op_p0 >= OP_MUL) && (op_p0 <= OP_REMU);
  assign is_div = (op_p0 >= OP_DIV);
  assign busy   = vld_p0 && is_md && (state_q != DONE);
  assign cap    = !io.stall_i && !busy;

  // ---- stage p0: instruction capture (flush wins over stall/busy)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            vld_p0 <= 1'b0;
    else if (io.flush_i) vld_p0 <= 1'b0;
    else if (cap)        vld_p0 <= io.in_valid;
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      pc_p0   <= io.in_pc;
      inst_p0 <= io.in_inst;
      op_p0   <= io.in_op;
      src1_p0 <= io.in_src1;
      src2_p0 <= io.in_src2;
      dest_p0 <= io.in_dest;
    end
  end

  logic signed [XLEN-1:0] s1_s, s2_s;
  logic [SHW-1:0]         shamt;
  logic [XLEN-1:0]        alu_res;
  assign s1_s  = src1_p0;
  assign s2_s  = src2_p0;
  assign shamt = src2_p0[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op_p0)
      OP_ADD:  alu_res = src1_p0 + src2_p0;
      OP_SUB:  alu_res = src1_p0 - src2_p0;
      OP_AND:  alu_res = src1_p0 & src2_p0;
      OP_OR:   alu_res = src1_p0 | src2_p0;
      OP_XOR:  alu_res = src1_p0 ^ src2_p0;
      OP_LUI:  alu_res = src2_p0;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, s1_s < s2_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src1_p0 < src2_p0};
      OP_SLL:  alu_res = src1_p0 << shamt;
      OP_SRL:  alu_res = src1_p0 >> shamt;
      OP_SRA:  alu_res = s1_s >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // ---- stage p1: iterative mul/div FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: if (vld_p0 && is_md) begin
        state_n = CALC;
        cnt_n   = '0;
      end
      CALC: begin
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_n = DONE;
      end
      DONE:    if (!io.stall_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (io.flush_i) state_n = IDLE;
  end

  logic sgn1, sgn2;
  assign sgn1 = src1_p0[XLEN-1] && (op_p0 == OP_MUL || op_p0 == OP_MULH || op_p0 == OP_MULHSU ||
                                    op_p0 == OP_DIV || op_p0 == OP_REM);
  assign sgn2 = src2_p0[XLEN-1] && (op_p0 == OP_MUL || op_p0 == OP_MULH ||
                                    op_p0 == OP_DIV || op_p0 == OP_REM);

  // hi:lo is the product accumulator for multiply and remainder:quotient for divide
  logic [XLEN:0]   mul_sum, div_sh;
  logic [XLEN-1:0] div_diff, step_hi, step_lo;
  logic            div_ge;

  always_comb begin
    mul_sum  = {1'b0, md_hi_p1} + (md_lo_p1[0] ? {1'b0, md_opd_p1} : '0);
    div_sh   = {md_hi_p1, md_lo_p1[XLEN-1]};
    div_ge   = div_sh >= {1'b0, md_opd_p1};
    div_diff = div_sh[XLEN-1:0] - md_opd_p1;
    if (is_div) begin
      step_hi = div_ge ? div_diff : div_sh[XLEN-1:0];
      step_lo = {md_lo_p1[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], md_lo_p1[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && vld_p0 && is_md) begin
      md_hi_p1   <= '0;
      md_lo_p1   <= is_div ? cond_neg(sgn1, src1_p0) : cond_neg(sgn2, src2_p0);
      md_opd_p1  <= is_div ? cond_neg(sgn2, src2_p0) : cond_neg(sgn1, src1_p0);
      md_neg1_p1 <= sgn1;
      md_neg2_p1 <= sgn2;
    end else if (state_q == CALC) begin
      md_hi_p1 <= step_hi;
      md_lo_p1 <= step_lo;
    end
  end

  // ---- result select: sign correction and RISC-V division corner cases
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, md_res;
  logic              div_zero, div_ovf;

  always_comb begin
    prod     = cond_neg_w(md_neg1_p1 ^ md_neg2_p1, {md_hi_p1, md_lo_p1});
    quo      = cond_neg(md_neg1_p1 ^ md_neg2_p1, md_lo_p1);
    rem      = cond_neg(md_neg1_p1, md_hi_p1);
    div_zero = (src2_p0 == '0);
    div_ovf  = (op_p0 == OP_DIV || op_p0 == OP_REM) && (src1_p0 == MOST_NEG) && (src2_p0 == '1);
    md_res   = '0;
    case (op_p0)
      OP_MUL:                       md_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              md_res = div_zero ? '1 : (div_ovf ? src1_p0 : quo);
      OP_REM, OP_REMU:              md_res = div_zero ? src1_p0 : (div_ovf ? '0 : rem);
      default:                      md_res = '0;
    endcase
  end

  assign res_vld     = vld_p0 && (is_alu || (is_md && state_q == DONE));
  assign io.out_valid = res_vld;
  assign io.busy_o    = busy;
  assign io.out_pc    = vld_p0 ? pc_p0 : '0;
  assign io.out_inst  = vld_p0 ? inst_p0 : '0;
  assign io.out_dest  = (vld_p0 && (is_alu || is_md)) ? dest_p0 : '0;
  assign io.out_res   = res_vld ? (is_md ? md_res : alu_res) : '0;
endmodule

// File: tb/tb_exec_md_stage.sv
// Bench for exec_md_stage: XLEN=32 and XLEN=64 instances share one stimulus bus,
// selected by sel64; results are compared against an arithmetic reference model.
module tb_exec_md_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel64, stall, flush, v_valid;
  logic [63:0] v_pc, v_src1, v_src2;
  logic [31:0] v_inst;
  logic [4:0]  v_op, v_dest;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] bexp [4];

  exec_md_stage_if #(.XLEN(32)) if32 ();
  exec_md_stage_if #(.XLEN(64)) if64 ();

  assign if32.stall_i  = stall;
  assign if32.flush_i  = flush;
  assign if32.in_valid = v_valid & ~sel64;
  assign if32.in_pc    = v_pc[31:0];
  assign if32.in_inst  = v_inst;
  assign if32.in_op    = v_op;
  assign if32.in_src1  = v_src1[31:0];
  assign if32.in_src2  = v_src2[31:0];
  assign if32.in_dest  = v_dest;
  assign if64.stall_i  = stall;
  assign if64.flush_i  = flush;
  assign if64.in_valid = v_valid & sel64;
  assign if64.in_pc    = v_pc;
  assign if64.in_inst  = v_inst;
  assign if64.in_op    = v_op;
  assign if64.in_src1  = v_src1;
  assign if64.in_src2  = v_src2;
  assign if64.in_dest  = v_dest;

  exec_md_stage #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .io(if32.slave));
  exec_md_stage #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .io(if64.slave));

  logic        o_valid, o_busy;
  logic [63:0] o_pc, o_res;
  logic [31:0] o_inst;
  logic [4:0]  o_dest;
  always_comb begin
    if (sel64) begin
      o_valid = if64.out_valid; o_busy = if64.busy_o; o_pc = if64.out_pc;
      o_res = if64.out_res; o_inst = if64.out_inst; o_dest = if64.out_dest;
    end else begin
      o_valid = if32.out_valid; o_busy = if32.busy_o; o_pc = {32'b0, if32.out_pc};
      o_res = {32'b0, if32.out_res}; o_inst = if32.out_inst; o_dest = if32.out_dest;
    end
  end

  function automatic int xlen();
    return sel64 ? 64 : 32;
  endfunction

  function automatic logic [63:0] wmask();
    return sel64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Reference: operands widened to 128-bit signed integers, ops done with plain arithmetic.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a_in,
                                        input logic [63:0] b_in, input int xl);
    logic [63:0] m, a, b, r;
    logic signed [127:0] ua, ub, sa, sb, p;
    int sh;
    m  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a  = a_in & m;
    b  = b_in & m;
    ua = {64'b0, a};
    ub = {64'b0, b};
    sa = a[xl-1] ? ua - (128'sd1 <<< xl) : ua;
    sb = b[xl-1] ? ub - (128'sd1 <<< xl) : ub;
    sh = int'(b[5:0]) & (xl - 1);
    p  = '0;
    r  = '0;
    case (op)
      5'd1:  r = a + b;
      5'd2:  r = a - b;
      5'd3:  r = a & b;
      5'd4:  r = a | b;
      5'd5:  r = a ^ b;
      5'd6:  r = b;
      5'd7:  r = (sa < sb) ? 64'd1 : 64'd0;
      5'd8:  r = (ua < ub) ? 64'd1 : 64'd0;
      5'd9:  r = a << sh;
      5'd10: r = a >> sh;
      5'd11: begin p = sa >>> sh; r = p[63:0]; end
      5'd12: begin p = sa * sb; r = p[63:0]; end
      5'd13: begin p = (sa * sb) >>> xl; r = p[63:0]; end
      5'd14: begin p = (sa * ub) >>> xl; r = p[63:0]; end
      5'd15: begin p = (ua * ub) >>> xl; r = p[63:0]; end
      5'd16: if (b == 0) r = '1; else begin p = sa / sb; r = p[63:0]; end
      5'd17: if (b == 0) r = '1; else begin p = ua / ub; r = p[63:0]; end
      5'd18: if (b == 0) r = a;  else begin p = sa % sb; r = p[63:0]; end
      5'd19: if (b == 0) r = a;  else begin p = ua % ub; r = p[63:0]; end
      default: r = '0;
    endcase
    return r & m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, {63'b0, o_valid}, 64'd0);
    check({tag, ".busy"},  {63'b0, o_busy},  64'd0);
    check({tag, ".dest"},  {59'b0, o_dest},  64'd0);
    check({tag, ".res"},   o_res,            64'd0);
    check({tag, ".pc"},    o_pc,             64'd0);
    check({tag, ".inst"},  {32'b0, o_inst},  64'd0);
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp);
    int cyc, bcnt;
    logic [4:0]  d;
    logic [63:0] pc;
    d  = 5'($urandom_range(1, 31));
    pc = {$urandom, $urandom} & wmask();
    @(negedge clk);
    v_op = op; v_src1 = a; v_src2 = b; v_dest = d; v_pc = pc; v_inst = $urandom; v_valid = 1'b1;
    @(negedge clk);
    v_valid = 1'b0;
    if (op <= 5'd11) begin
      check({tag, ".valid"}, {63'b0, o_valid}, 64'd1);
      check({tag, ".res"},   o_res,            exp);
      check({tag, ".dest"},  {59'b0, o_dest},  {59'b0, d});
      check({tag, ".pc"},    o_pc,             pc);
    end else begin
      cyc = 1;
      bcnt = 0;
      while (!o_valid && cyc < 200) begin
        if (o_busy) bcnt++;
        @(negedge clk);
        cyc++;
      end
      check({tag, ".latency"}, 64'(cyc),  64'(xlen() + 2));
      check({tag, ".busycyc"}, 64'(bcnt), 64'(xlen() + 1));
      check({tag, ".res"},     o_res,     exp);
      check({tag, ".dest"},    {59'b0, o_dest}, {59'b0, d});
      check({tag, ".busy"},    {63'b0, o_busy}, 64'd0);
    end
  endtask

  task automatic run_bad(input string tag, input logic [4:0] op, input logic vld);
    @(negedge clk);
    v_op = op; v_src1 = {$urandom, $urandom}; v_src2 = {$urandom, $urandom};
    v_dest = 5'd7; v_valid = vld;
    @(negedge clk);
    v_valid = 1'b0;
    check({tag, ".valid"}, {63'b0, o_valid}, 64'd0);
    check({tag, ".dest"},  {59'b0, o_dest},  64'd0);
    check({tag, ".res"},   o_res,            64'd0);
  endtask

  function automatic logic [63:0] rnd_opd();
    logic [63:0] m;
    m = wmask();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return m;
      3: return (m >> 1) + 64'd1;
      4: return (m >> 1);
      5: return 64'($urandom_range(0, 40));
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  task automatic random_ops(input int n);
    logic [4:0]  op;
    logic [63:0] a, b;
    for (int i = 0; i < n; i++) begin
      op = 5'($urandom_range(1, 19));
      a  = rnd_opd();
      b  = rnd_opd();
      run_op("rand", op, a, b, model(op, a, b, xlen()));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, vcnt;
    logic [4:0] da, db;
    sel64 = 1'b0; stall = 1'b0; flush = 1'b0; v_valid = 1'b0;
    v_pc = '0; v_src1 = '0; v_src2 = '0; v_inst = '0; v_op = '0; v_dest = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_zero("reset_async");
    repeat (2) @(negedge clk);
    check_zero("reset32");
    sel64 = 1'b1;
    #1 check_zero("reset64");
    sel64 = 1'b0;
    rst = 1'b1;

    // XLEN=32 directed ALU sweep
    run_op("add_ovf", 5'd1,  64'h7FFF_FFFF, 64'h1,         64'h8000_0000);
    run_op("sub",     5'd2,  64'h5,         64'h7,         64'hFFFF_FFFE);
    run_op("slt",     5'd7,  64'hFFFF_FFFF, 64'h1,         64'h1);
    run_op("sltu",    5'd8,  64'hFFFF_FFFF, 64'h1,         64'h0);
    run_op("sra_msk", 5'd11, 64'h8000_0000, 64'h21,        64'hC000_0000);
    run_op("sll_msk", 5'd9,  64'h1,         64'h25,        64'h20);
    run_op("srl",     5'd10, 64'h8000_0000, 64'h3F,        64'h1);
    run_op("lui",     5'd6,  64'h1234,      64'hABCD_E000, 64'hABCD_E000);

    // back-to-back ALU, one per cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b.valid", {63'b0, o_valid}, 64'd1);
        check("b2b.res", o_res, bexp[i-1]);
      end
      v_op = 5'd1; v_src1 = 64'(i * 3 + 1); v_src2 = 64'd100; v_dest = 5'd3; v_valid = 1'b1;
      bexp[i] = 64'(i * 3 + 101);
    end
    @(negedge clk);
    v_valid = 1'b0;
    check("b2b.last", o_res, bexp[3]);

    // XLEN=32 mul/div
    run_op("mulh_min",  5'd13, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000);
    run_op("mulhsu",    5'd14, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    run_op("mul",       5'd12, 64'h3,         64'hFFFF_FFFB, 64'hFFFF_FFF1);
    run_op("mulhu",     5'd15, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE);
    run_op("div_z",     5'd16, 64'h7,         64'h0,         64'hFFFF_FFFF);
    run_op("rem_z",     5'd18, 64'h7,         64'h0,         64'h7);
    run_op("div_ovf",   5'd16, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000);
    run_op("rem_ovf",   5'd18, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0);
    run_op("div_neg",   5'd16, 64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFD);
    run_op("rem_neg",   5'd18, 64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFF);
    run_op("remu",      5'd19, 64'd100,       64'd7,         64'd2);

    // stall from cycle 10 of a DIVU until 5 cycles past DONE, with an ADD waiting
    da = 5'd9; db = 5'd21;
    @(negedge clk);
    v_op = 5'd17; v_src1 = 64'd1000; v_src2 = 64'd7; v_dest = da; v_valid = 1'b1;
    @(negedge clk);
    v_op = 5'd1; v_src1 = 64'd5; v_src2 = 64'd6; v_dest = db;
    cyc = 1;
    while (cyc < xlen() + 2) begin
      if (cyc == 10) stall = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("hold.valid", {63'b0, o_valid}, 64'd1);
    check("hold.res", o_res, 64'd142);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold.stable_valid", {63'b0, o_valid}, 64'd1);
      check("hold.stable_res", o_res, 64'd142);
      check("hold.no_capture", {59'b0, o_dest}, {59'b0, da});
    end
    stall = 1'b0;
    @(negedge clk);
    v_valid = 1'b0;
    check("hold.next_valid", {63'b0, o_valid}, 64'd1);
    check("hold.next_res", o_res, 64'd11);
    check("hold.next_dest", {59'b0, o_dest}, {59'b0, db});

    // flush in CALC iteration 5
    @(negedge clk);
    v_op = 5'd16; v_src1 = 64'd100; v_src2 = 64'd7; v_dest = 5'd4; v_valid = 1'b1;
    @(negedge clk);
    v_valid = 1'b0;
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.busy", {63'b0, o_busy}, 64'd0);
    vcnt = 0;
    for (int i = 0; i < xlen() + 4; i++) begin
      if (o_valid) vcnt++;
      @(negedge clk);
    end
    check("flush.no_result", 64'(vcnt), 64'd0);
    run_op("flush.next_add", 5'd1, 64'd40, 64'd2, 64'd42);
    run_op("flush.next_mul", 5'd12, 64'd6, 64'd7, 64'd42);

    // asynchronous reset mid-CALC
    @(negedge clk);
    v_op = 5'd12; v_src1 = 64'd9; v_src2 = 64'd9; v_dest = 5'd5; v_pc = 64'h44; v_valid = 1'b1;
    @(negedge clk);
    v_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    vcnt = 0;
    for (int i = 0; i < xlen() + 4; i++) begin
      if (o_valid || o_busy) vcnt++;
      @(negedge clk);
    end
    check("rst_mid.no_result", 64'(vcnt), 64'd0);

    run_bad("nop", 5'd0, 1'b1);
    run_bad("illegal25", 5'd25, 1'b1);
    run_bad("invalid", 5'd1, 1'b0);

    random_ops(30);

    // XLEN=64
    sel64 = 1'b1;
    run_op("add64",   5'd1,  64'h7FFF_FFFF_FFFF_FFFF, 64'h1,  64'h8000_0000_0000_0000);
    run_op("slt64",   5'd7,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1,  64'h1);
    run_op("sltu64",  5'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1,  64'h0);
    run_op("sra64",   5'd11, 64'h8000_0000_0000_0000, 64'h41, 64'hC000_0000_0000_0000);
    run_op("sll64",   5'd9,  64'h1,                   64'h7F, 64'h8000_0000_0000_0000);
    run_op("mulh64",  5'd13, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000);
    run_op("mulhsu64", 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF);
    run_op("div_ovf64", 5'd16, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000);
    run_op("rem_neg64", 5'd18, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("div_z64",   5'd16, 64'h7, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_bad("illegal64", 5'd25, 1'b1);
    random_ops(16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_md_stage.md
# exec_md_stage

Parametrised execute stage: a pipeline register feeding a single-cycle integer ALU, plus an iterative multiply/divide unit covering the RV32M/RV64M operation set. It sits between decode and writeback. Single-cycle ops produce a result the cycle after capture. Mul/div ops hold the stage busy for a fixed number of iterations and back-pressure decode through `busy_o`. It extends the RV32I execute stage with width parametrisation, correct shift-amount masking, M-extension support, a busy handshake and a flush.

## Interface
Parameters:
- `XLEN`, 32: datapath width; legal values 32 and 64.
- `SHW`, $clog2(XLEN): derived shift-amount width; not overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `stall_i`  in  1  downstream stall; blocks capture of a new instruction.
- `flush_i`  in  1  synchronous kill of the held instruction and any in-flight mul/div.
- `in_valid`  in  1  instruction valid.
- `in_pc`  in  XLEN  instruction PC.
- `in_inst`  in  32  raw instruction word.
- `in_op`  in  5  operation code.
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LUI (pass `src2`), 7 SLT, 8 SLTU, 9 SLL, 10 SRL, 11 SRA.
  - 12 MUL, 13 MULH, 14 MULHSU, 15 MULHU, 16 DIV, 17 DIVU, 18 REM, 19 REMU.
  - 20–31 illegal.
- `in_src1`, `in_src2`  in  XLEN  operands.
- `in_dest`  in  5  destination register.
- `out_valid`  out  1  result valid this cycle.
- `out_pc`  out  XLEN  PC of the held instruction.
- `out_inst`  out  32  instruction word of the held instruction.
- `out_dest`  out  5  destination register; 0 for NOP, illegal or invalid instructions.
- `out_res`  out  XLEN  result.
- `busy_o`  out  1  mul/div in progress; decode must hold its outputs.

## Operation
- Stage register captures all `in_*` when `stall_i`=0 and `busy_o`=0.
  - `flush_i`=1 clears its valid bit instead; flush has priority over stall and busy.
- ALU ops (1–11), computed from the stage register:
  - SLT: signed compare. SLTU: unsigned compare. Result is 0 or 1, zero-extended.
  - Shift amount is `src2[SHW-1:0]`; upper bits are ignored.
  - SRA sign-fills from `src1[XLEN-1]`.
- Mul/div FSM states: IDLE, CALC, DONE.
  - IDLE: when the held instruction is valid with op 12–19, latch absolute operand values and sign flags, clear the counter, and go to CALC.
  - CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle. Counter runs 0..XLEN-1. At XLEN-1, go to DONE.
  - DONE: apply sign correction and select the result.
    - MUL returns the low half of the 2·XLEN product.
    - MULH, MULHSU, MULHU return the high half; MULHSU treats `src1` as signed and `src2` as unsigned.
    - Leave DONE on the first edge with `stall_i`=0, to IDLE.
- RISC-V division corner cases, applied in DONE with iteration count unchanged:
  - Divide by zero: quotient = all ones, remainder = `src1`.
  - Signed overflow (most-negative ÷ −1): quotient = `src1`, remainder = 0.
- Output qualification:
  - `out_valid` = held valid AND op ≠ NOP AND op not illegal AND (op is an ALU op OR state = DONE).
  - For NOP, illegal or invalid instructions: `out_dest`=0 and `out_res`=0.
- `busy_o` = 1 when the held instruction is a valid mul/div and state ≠ DONE.
- `flush_i` during CALC or DONE returns the FSM to IDLE on the next edge and drops the result.

## Timing
- Reset (asynchronous): stage register valid=0, FSM=IDLE, counter=0.
  - Outputs: `out_valid`=0, `busy_o`=0, `out_dest`=0, `out_res`=0, `out_pc`=0, `out_inst`=0.
- Reset asserted mid-CALC aborts immediately; no result is produced after release.
- ALU op latency: 1 cycle (captured at edge E, `out_valid` in the cycle after E).
- Mul/div latency, for a capture at edge E:
  - The cycle after E is IDLE with `busy_o`=1.
  - Then XLEN CALC cycles.
  - DONE is in cycle XLEN+2 after E, with `out_valid`=1 and `busy_o`=0.
  - A new instruction can be captured at the end of DONE if `stall_i`=0.
- Back-to-back ALU ops sustain 1 instruction per cycle.
- Mul/div throughput: 1 per XLEN+2 cycles.
- `stall_i` during CALC does not pause iteration.
- `stall_i` during DONE holds DONE, with `out_res` and `out_valid` stable.
- Outputs are combinational from the stage register and FSM state; no input-to-output combinational path.

## Test plan
- ALU sweep, XLEN=32:
  - ADD 0x7FFFFFFF+1 → 0x80000000.
  - SLT(−1,1) → 1; SLTU(−1,1) → 0.
  - SRA(0x80000000, src2=0x21) → 0xC0000000 (shift of 1, upper src2 bits ignored).
- MULH(0x80000000, 0x80000000) → 0x40000000. MULHSU(−1, 0xFFFFFFFF) → 0xFFFFFFFF.
  - `out_valid` rises exactly 34 cycles after capture.
  - `busy_o` is high for exactly 33 cycles.
- DIV(7,0) → 0xFFFFFFFF; REM(7,0) → 7; DIV(0x80000000, −1) → 0x80000000; REM of the same → 0; DIV(−7,2) → −3; REM(−7,2) → −1.
- Hold behaviour:
  - `stall_i` held high from cycle 10 of a DIVU through 5 cycles past DONE: result stays stable, DONE persists, no new capture.
  - After release, the next ADD is captured at the edge that exits DONE.
- Kill behaviour:
  - `flush_i` in cycle 5 of CALC: FSM returns to IDLE, no `out_valid` for the dropped op, next instruction accepted.
  - `rst` pulse mid-CALC: all outputs 0 asynchronously.
- NOP, illegal op 25 and `in_valid`=0 each give `out_valid`=0, `out_dest`=0, `out_res`=0.
- Repeat the ALU sweep and MUL/DIV at XLEN=64: latency is 66 cycles.
